wb_ram_bus_demux: RTL and testbench
===================================

// Module: wb_ram_bus_demux
// PURPOSE
// - Registered Wishbone 1-to-N demultiplexer between the user-area master (UFP) and N RAM-type slaves (HyperRAM, OpenRAM, ...).
// - Decodes ADR[31:16] against per-port mask/match windows and latches the selected port for the whole transaction.
// - Drives exactly one downstream port and returns its ACK/DAT to the UFP.
// - Unmapped accesses, and (optionally) hung slaves, are terminated with an error instead of stalling the bus.
// PARAMETERS
// - N_PORTS      2                                 number of downstream ports, 1..8
// - PORT_ADDR_HI {16'h30c0,16'h3000}               packed 16*N_PORTS; match value for ADR[31:16], port i at [16*i+:16]
// - PORT_ADDR_MSK {16'hffff,16'hff80}              packed 16*N_PORTS; mask ANDed with ADR[31:16] before compare
// - TIMEOUT_CYC  255                               cycles in BUSY without ACK before abort, 1..65535
// PORTS
// - wb_clk_i          in   1        bus clock, all logic rising-edge
// - wb_rst_n_i        in   1        reset, synchronous, active-low
// - wbs_ufp_stb_i     in   1        UFP strobe
// - wbs_ufp_cyc_i     in   1        UFP cycle
// - wbs_ufp_we_i      in   1        UFP write enable
// - wbs_ufp_sel_i     in   4        UFP byte selects
// - wbs_ufp_adr_i     in   32       UFP address
// - wbs_ufp_dat_i     in   32       UFP write data
// - wbs_ufp_ack_o     out  1        UFP acknowledge, single-cycle pulse
// - wbs_ufp_err_o     out  1        UFP error, single-cycle pulse, never together with ack
// - wbs_ufp_dat_o     out  32       UFP read data, valid with ack
// - wbs_dfp_stb_o     out  N_PORTS  per-port strobe
// - wbs_dfp_cyc_o     out  N_PORTS  per-port cycle
// - wbs_dfp_we_o      out  1        shared latched write enable
// - wbs_dfp_sel_o     out  4        shared latched byte selects
// - wbs_dfp_adr_o     out  32       shared latched address
// - wbs_dfp_dat_o     out  32       shared latched write data
// - wbs_dfp_dat_i     in   32*N     per-port read data, port i at [32*i+:32]
// - wbs_dfp_ack_i     in   N_PORTS  per-port acknowledge
// BEHAVIOUR
// - Reset (wb_rst_n_i=0 at clock edge): state IDLE; all *_o = 0; timeout counter = 0.
// - Reset mid-transaction aborts silently: no ack/err, DFP stb/cyc low next cycle.
// - Decode: hit[i] = (ADR[31:16] & MSK[i]) == HI[i]. Lowest index wins on overlap. No hit means unmapped.
// - FSM IDLE: on cyc&stb:
//   - mapped: latch port index, adr, we, sel, dat; next cycle stb/cyc[port]=1 -> BUSY.
//   - unmapped: -> RESP with err_o=1, dat_o=0.
// - FSM BUSY:
//   - on dfp_ack_i[port]: ack_o=1 next cycle, dat_o <= dfp_dat_i[port] (writes: dat_o=0); stb/cyc[port] drop same edge -> RESP.
//   - ACK on non-selected ports is ignored.
//   - ufp_cyc_i low: abort, stb/cyc drop next cycle, -> IDLE, no ack/err.
// - FSM RESP: ack_o/err_o high exactly this one cycle; UFP inputs ignored; -> IDLE. The cycle after ack is always dead (not pipelined).
// - Latency: request seen cycle 0 -> dfp stb cycle 1 -> slave ack cycle k>=1 -> ufp ack cycle k+1. Minimum 2 cycles; unmapped err at cycle 1.
// - Outputs are registered and change only on the clock edge; dfp_stb_o/dfp_cyc_o are one-hot or zero.
// - Latched request fields are held stable for all of BUSY even if UFP inputs change.
// - dat_o returns to 0 the cycle after RESP.
// CONFIGURATION
// - Macro WB_RAM_BUS_DEMUX_TIMEOUT_EN.
//   - Defined: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle. Reaching TIMEOUT_CYC without ACK:
//     drop stb/cyc, err_o=1 and dat_o=32'hdead_beef next cycle, -> RESP. ACK in the same cycle as expiry wins (normal ack).
//   - Undefined: no counter; BUSY waits indefinitely for ACK or for cyc to drop; TIMEOUT_CYC unused.
// TESTING
// - Read ADR=0x3000_0010 with port0 acking 3 cycles after stb, dat=0x1234_5678 -> only stb[0]; ufp ack 1 pulse, dat_o=0x1234_5678.
// - Write ADR=0x30c0_0004, dat=0xA5A5_A5A5, sel=4'b0011 -> dfp adr/dat/sel/we latched, stb[1] only; ack 1 cycle after dfp ack[1].
// - Read ADR=0x4000_0000 (unmapped) -> no dfp stb; err_o pulse at cycle 1, dat_o=0; next request accepted at cycle 3.
// - Spurious ack[1] while port0 busy -> ignored; ack only after ack[0]; ufp_cyc_i dropped in BUSY -> dfp stb/cyc low, no ack/err.
// - TIMEOUT_EN, TIMEOUT_CYC=8, port0 never acks -> err_o at BUSY cycle 9, dat_o=0xdead_beef; without macro bus stays in BUSY.
// - wb_rst_n_i=0 during BUSY -> all outputs 0 next edge; after release a fresh read completes normally.

Source files
------------

// File: rtl/wb_ram_bus_demux.sv
// Registered Wishbone 1-to-N demultiplexer from the user-area master to RAM-type slaves.
// Optional slave watchdog: define WB_RAM_BUS_DEMUX_TIMEOUT_EN.
module wb_ram_bus_demux #(
   parameter int                    N_PORTS       = 2,
   parameter logic [16*N_PORTS-1:0] PORT_ADDR_HI  = {16'h30c0, 16'h3000},
   parameter logic [16*N_PORTS-1:0] PORT_ADDR_MSK = {16'hffff, 16'hff80},
   parameter int                    TIMEOUT_CYC   = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_n_i,
   input  logic                   wbs_ufp_stb_i,
   input  logic                   wbs_ufp_cyc_i,
   input  logic                   wbs_ufp_we_i,
   input  logic [3:0]             wbs_ufp_sel_i,
   input  logic [31:0]            wbs_ufp_adr_i,
   input  logic [31:0]            wbs_ufp_dat_i,
   output logic                   wbs_ufp_ack_o,
   output logic                   wbs_ufp_err_o,
   output logic [31:0]            wbs_ufp_dat_o,
   output logic [N_PORTS-1:0]     wbs_dfp_stb_o,
   output logic [N_PORTS-1:0]     wbs_dfp_cyc_o,
   output logic                   wbs_dfp_we_o,
   output logic [3:0]             wbs_dfp_sel_o,
   output logic [31:0]            wbs_dfp_adr_o,
   output logic [31:0]            wbs_dfp_dat_o,
   input  logic [32*N_PORTS-1:0]  wbs_dfp_dat_i,
   input  logic [N_PORTS-1:0]     wbs_dfp_ack_i
);

   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        port_q, port_d;
   logic [N_PORTS-1:0]   stb_q, stb_d;
   logic                 we_q, we_d;
   logic [3:0]           sel_q, sel_d;
   logic [31:0]          adr_q, adr_d;
   logic [31:0]          wdat_q, wdat_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic [31:0]          rdat_q, rdat_d;
   logic                 hit_any;
   logic [PW-1:0]        hit_idx;
`ifdef WB_RAM_BUS_DEMUX_TIMEOUT_EN
   logic [15:0]          cnt_q, cnt_d;
`endif

   // Descending scan so the lowest matching index overrides higher ones.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if ((wbs_ufp_adr_i[31:16] & PORT_ADDR_MSK[16*i +: 16]) == PORT_ADDR_HI[16*i +: 16]) begin
            hit_any = 1'b1;
            hit_idx = PW'(i);
         end
      end
   end

   always_comb begin
      // NOTE: every target gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d = state_q;
      port_d  = port_q;
      stb_d   = stb_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdat_d  = '0;
`ifdef WB_RAM_BUS_DEMUX_TIMEOUT_EN
      cnt_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (wbs_ufp_cyc_i && wbs_ufp_stb_i) begin
               if (hit_any) begin
                  port_d         = hit_idx;
                  we_d           = wbs_ufp_we_i;
                  sel_d          = wbs_ufp_sel_i;
                  adr_d          = wbs_ufp_adr_i;
                  wdat_d         = wbs_ufp_dat_i;
                  stb_d          = '0;
                  stb_d[hit_idx] = 1'b1;
                  state_d        = BUSY;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         BUSY: begin
`ifdef WB_RAM_BUS_DEMUX_TIMEOUT_EN
            cnt_d = cnt_q + 16'd1;
`endif
            // A master that drops cyc no longer wants any response.
            if (!wbs_ufp_cyc_i) begin
               stb_d   = '0;
               state_d = IDLE;
            end else if (wbs_dfp_ack_i[port_q]) begin
               stb_d   = '0;
               ack_d   = 1'b1;
               rdat_d  = we_q ? 32'h0 : wbs_dfp_dat_i[32*port_q +: 32];
               state_d = RESP;
`ifdef WB_RAM_BUS_DEMUX_TIMEOUT_EN
            end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
               stb_d   = '0;
               err_d   = 1'b1;
               rdat_d  = 32'hdead_beef;
               state_d = RESP;
`endif
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
         port_q  <= '0;
         stb_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
      end
   end

`ifdef WB_RAM_BUS_DEMUX_TIMEOUT_EN
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) cnt_q <= '0;
      else             cnt_q <= cnt_d;
   end
`endif

   assign wbs_ufp_ack_o = ack_q;
   assign wbs_ufp_err_o = err_q;
   assign wbs_ufp_dat_o = rdat_q;
   assign wbs_dfp_stb_o = stb_q;
   assign wbs_dfp_cyc_o = stb_q;
   assign wbs_dfp_we_o  = we_q;
   assign wbs_dfp_sel_o = sel_q;
   assign wbs_dfp_adr_o = adr_q;
   assign wbs_dfp_dat_o = wdat_q;

endmodule

// File: tb/tb_wb_ram_bus_demux.sv
// Scoreboard bench for wb_ram_bus_demux with two behavioural RAM slaves.
// Covers the watchdog path when WB_RAM_BUS_DEMUX_TIMEOUT_EN is defined.
module tb_wb_ram_bus_demux;

   localparam int N = 2;

   typedef struct {
      bit          is_err;
      logic [31:0] dat;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cyc, stb, we;
   logic [3:0]    sel;
   logic [31:0]   adr, wdat;
   logic          ack, err;
   logic [31:0]   rdat;
   logic [N-1:0]  dfp_stb, dfp_cyc, dfp_ack;
   logic          dfp_we;
   logic [3:0]    dfp_sel;
   logic [31:0]   dfp_adr, dfp_wdat;
   logic [32*N-1:0] dfp_rdat;

   int            n_tests = 0;
   int            n_fail  = 0;
   rsp_t          sb[$];
   rsp_t          mon_r;

   int            slave_delay [N];
   logic [31:0]   slave_data  [N];
   bit            slave_en    [N];
   int            slave_cnt   [N];
   logic [N-1:0]  spur;

   always #5 clk = ~clk;

   wb_ram_bus_demux #(
      .N_PORTS       (N),
      .PORT_ADDR_HI  ({16'h30c0, 16'h3000}),
      .PORT_ADDR_MSK ({16'hffff, 16'hff80}),
      .TIMEOUT_CYC   (8)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_n_i    (rst_n),
      .wbs_ufp_stb_i (stb),
      .wbs_ufp_cyc_i (cyc),
      .wbs_ufp_we_i  (we),
      .wbs_ufp_sel_i (sel),
      .wbs_ufp_adr_i (adr),
      .wbs_ufp_dat_i (wdat),
      .wbs_ufp_ack_o (ack),
      .wbs_ufp_err_o (err),
      .wbs_ufp_dat_o (rdat),
      .wbs_dfp_stb_o (dfp_stb),
      .wbs_dfp_cyc_o (dfp_cyc),
      .wbs_dfp_we_o  (dfp_we),
      .wbs_dfp_sel_o (dfp_sel),
      .wbs_dfp_adr_o (dfp_adr),
      .wbs_dfp_dat_o (dfp_wdat),
      .wbs_dfp_dat_i (dfp_rdat),
      .wbs_dfp_ack_i (dfp_ack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Slaves: ack once stb has been seen for slave_delay cycles; read data is noise otherwise.
   initial begin
      dfp_ack  = '0;
      dfp_rdat = '0;
      forever begin
         @(posedge clk);
         #1;
         dfp_ack = '0;
         for (int p = 0; p < N; p++) begin
            dfp_rdat[32*p +: 32] = $urandom;
            if (dfp_stb[p]) begin
               if (slave_en[p] && slave_cnt[p] >= slave_delay[p]) begin
                  dfp_ack[p]           = 1'b1;
                  dfp_rdat[32*p +: 32] = slave_data[p];
               end
               slave_cnt[p]++;
            end else begin
               slave_cnt[p] = 0;
            end
         end
         dfp_ack = dfp_ack | spur;
      end
   end

   // Response monitor: every ack/err must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         check("ack_err_excl", {31'd0, ack & err}, 32'd0);
         check("stb_eq_cyc", {30'd0, dfp_stb}, {30'd0, dfp_cyc});
         check("stb_onehot", {31'd0, $countones(dfp_stb) <= 1}, 32'd1);
         if (ack || err) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", {30'd0, ack, err}, 32'd0);
            end else begin
               mon_r = sb.pop_front();
               check("rsp_err", {31'd0, err}, {31'd0, mon_r.is_err});
               check("rsp_ack", {31'd0, ack}, {31'd0, !mon_r.is_err});
               check("rsp_dat", rdat, mon_r.dat);
            end
         end else begin
            check("dat_idle", rdat, 32'd0);
         end
      end
   end

   // One UFP transaction. port < 0 means unmapped; delay < 0 means the slave never acks.
   task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                         input int port, input int delay, input logic [31:0] sdat,
                         input int exp_lat, input bit exp_err, input logic [31:0] exp_dat);
      rsp_t       r;
      logic [1:0] exp_stb;
      bit         seen;
      int         n;
      exp_stb = '0;
      if (port >= 0) begin
         exp_stb[port]     = 1'b1;
         slave_en[port]    = (delay >= 0);
         slave_delay[port] = delay;
         slave_data[port]  = sdat;
      end
      r.is_err = exp_err;
      r.dat    = exp_dat;
      sb.push_back(r);
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
      seen = 1'b0;
      n    = 0;
      for (int i = 1; i <= 60 && !seen; i++) begin
         @(posedge clk);
         #1;
         n = i;
         if (i == 1) begin
            check("dfp_stb_c1", {30'd0, dfp_stb}, {30'd0, exp_stb});
            if (port >= 0) begin
               check("dfp_adr", dfp_adr, a);
               check("dfp_wdat", dfp_wdat, d);
               check("dfp_sel", {28'd0, dfp_sel}, {28'd0, s});
               check("dfp_we", {31'd0, dfp_we}, {31'd0, w});
            end
         end
         if (ack || err) seen = 1'b1;
      end
      check("rsp_seen", {31'd0, seen}, 32'd1);
      check("latency", n, exp_lat);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk);
      #1;
      check("dead_after_rsp", {29'd0, ack, err, |dfp_stb}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
      spur = '0;
      for (int p = 0; p < N; p++) begin
         slave_en[p] = 1'b0; slave_delay[p] = 0; slave_data[p] = '0; slave_cnt[p] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack_err", {30'd0, ack, err}, 32'd0);
      check("rst_rdat", rdat, 32'd0);
      check("rst_stb", {28'd0, dfp_stb, dfp_cyc}, 32'd0);
      check("rst_adr", dfp_adr, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mapped reads/writes, decode boundaries, unmapped error.
      do_req(32'h3000_0010, 1'b0, 4'hf, 32'h0, 0, 3, 32'h1234_5678, 5, 1'b0, 32'h1234_5678);
      do_req(32'h30c0_0004, 1'b1, 4'b0011, 32'ha5a5_a5a5, 1, 0, 32'hffff_ffff, 2, 1'b0, 32'h0);
      do_req(32'h4000_0000, 1'b0, 4'hf, 32'h0, -1, 0, 32'h0, 1, 1'b1, 32'h0);
      do_req(32'h307f_fffc, 1'b0, 4'hf, 32'h0, 0, 1, 32'h0bad_f00d, 3, 1'b0, 32'h0bad_f00d);
      do_req(32'h30c1_0000, 1'b0, 4'hf, 32'h0, -1, 0, 32'h0, 1, 1'b1, 32'h0);
      do_req(32'h30c0_fff0, 1'b0, 4'h1, 32'h0, 1, 2, 32'h8765_4321, 4, 1'b0, 32'h8765_4321);
      do_req(32'h3000_0020, 1'b1, 4'hc, 32'h5555_aaaa, 0, 1, 32'h1111_1111, 3, 1'b0, 32'h0);

      // Spurious ack on port 1 while port 0 is busy; UFP inputs change mid-BUSY.
      slave_en[0] = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf; adr = 32'h3000_0100; wdat = 32'h0;
      @(posedge clk);
      #1;
      adr = 32'h30c0_0000; wdat = 32'hffff_0000; we = 1'b1; sel = 4'h0;
      spur = 2'b10;
      repeat (2) @(posedge clk);
      #1;
      spur = '0;
      check("spur_no_ack", {30'd0, ack, err}, 32'd0);
      check("hold_stb", {30'd0, dfp_stb}, 32'd1);
      check("hold_adr", dfp_adr, 32'h3000_0100);
      check("hold_we_sel", {27'd0, dfp_we, dfp_sel}, {27'd0, 1'b0, 4'hf});
      begin
         rsp_t r;
         r.is_err = 1'b0; r.dat = 32'hcafe_f00d;
         sb.push_back(r);
      end
      slave_data[0] = 32'hcafe_f00d; slave_delay[0] = 0; slave_en[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0;
      check("spur_drained", sb.size(), 0);

      // Master abort: cyc dropped during BUSY.
      slave_en[0] = 1'b0;
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0200;
      repeat (3) @(posedge clk);
      #1;
      check("abort_busy_stb", {30'd0, dfp_stb}, 32'd1);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk);
      #1;
      check("abort_stb", {28'd0, dfp_stb, dfp_cyc}, 32'd0);
      check("abort_no_rsp", {30'd0, ack, err}, 32'd0);
      repeat (2) @(posedge clk);
      #1;

`ifdef WB_RAM_BUS_DEMUX_TIMEOUT_EN
      do_req(32'h3000_0300, 1'b0, 4'hf, 32'h0, 0, -1, 32'h0, 9, 1'b1, 32'hdead_beef);
`else
      slave_en[0] = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0300;
      repeat (300) @(posedge clk);
      #1;
      check("hang_stb", {30'd0, dfp_stb}, 32'd1);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk);
      #1;
      check("hang_abort_stb", {30'd0, dfp_stb}, 32'd0);
`endif

      // Reset during BUSY.
      slave_en[0] = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h5; adr = 32'h3000_0400; wdat = 32'h1357_9bdf;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_stb", {28'd0, dfp_stb, dfp_cyc}, 32'd0);
      check("mid_rst_rsp", {30'd0, ack, err}, 32'd0);
      check("mid_rst_fields", {27'd0, dfp_we, dfp_sel}, 32'd0);
      check("mid_rst_adr", dfp_adr, 32'd0);
      check("mid_rst_wdat", dfp_wdat, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_req(32'h3000_0500, 1'b0, 4'hf, 32'h0, 0, 2, 32'h2468_ace0, 4, 1'b0, 32'h2468_ace0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
